// File: rtl/arc4_pkg.sv
// rtl/arc4_pkg.sv - shared types and printable-range defaults for the plaintext checker
package arc4_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    LEN_WAIT,
    LEN_LATCH,
    BYTE_WAIT,
    BYTE_CHECK
  } pt_state_e;

  localparam byte_t PT_LO = 8'h20;
  localparam byte_t PT_HI = 8'h7E;

endpackage

// File: rtl/pt_range_cmp.sv
// rtl/pt_range_cmp.sv - combinational inclusive range compare on one plaintext byte
import arc4_pkg::*;

module pt_range_cmp #(
  parameter byte_t LO = PT_LO,
  parameter byte_t HI = PT_HI
) (
  input  logic [7:0] data_i,
  output logic       in_range_o
);

  assign in_range_o = (data_i >= LO) && (data_i <= HI);

endmodule

// File: rtl/pt_check.sv
// rtl/pt_check.sv - length-prefixed plaintext printable-ASCII validator
// Optional PT_CHECK_EARLY_EXIT_EN: stop at the first bad byte instead of a constant-time scan.
import arc4_pkg::*;

module pt_check #(
  parameter byte_t LO = PT_LO,
  parameter byte_t HI = PT_HI
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic       valid,
  output logic [7:0] bad_idx,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata
);

  pt_state_e state_q;
  logic      rdy_q;
  logic      valid_q;
  byte_t     bad_idx_q;
  byte_t     pt_addr_q;
  byte_t     idx_q;
  byte_t     len_q;
  logic      ok_q;
  logic      good;

  pt_range_cmp #(.LO(LO), .HI(HI)) u_range_cmp (
    .data_i     (pt_rddata),
    .in_range_o (good)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rdy_q     <= 1'b1;
      valid_q   <= 1'b0;
      bad_idx_q <= 8'd0;
      pt_addr_q <= 8'd0;
      idx_q     <= 8'd0;
      len_q     <= 8'd0;
      ok_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            rdy_q     <= 1'b0;
            valid_q   <= 1'b0;
            bad_idx_q <= 8'd0;
            pt_addr_q <= 8'd0;
            state_q   <= LEN_WAIT;
          end
        end
        LEN_WAIT: state_q <= LEN_LATCH;
        LEN_LATCH: begin
          len_q <= pt_rddata;
          if (pt_rddata == 8'd0) begin
            valid_q <= 1'b1;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            idx_q     <= 8'd1;
            ok_q      <= 1'b1;
            pt_addr_q <= 8'd1;
            state_q   <= BYTE_WAIT;
          end
        end
        BYTE_WAIT: state_q <= BYTE_CHECK;
        BYTE_CHECK: begin
          // ok_q gates the capture so bad_idx keeps the first failure only
          if (!good && ok_q) begin
            ok_q      <= 1'b0;
            bad_idx_q <= idx_q;
          end
`ifdef PT_CHECK_EARLY_EXIT_EN
          if (!good) begin
            valid_q <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end else if (idx_q == len_q) begin
            valid_q <= ok_q;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            idx_q     <= idx_q + 8'd1;
            pt_addr_q <= idx_q + 8'd1;
            state_q   <= BYTE_WAIT;
          end
`else
          if (idx_q == len_q) begin
            valid_q <= ok_q && good;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            idx_q     <= idx_q + 8'd1;
            pt_addr_q <= idx_q + 8'd1;
            state_q   <= BYTE_WAIT;
          end
`endif
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign rdy     = rdy_q;
  assign valid   = valid_q;
  assign bad_idx = bad_idx_q;
  assign pt_addr = pt_addr_q;

endmodule

// File: tb/tb_pt_check.sv
// tb/tb_pt_check.sv - scoreboard bench for pt_check with a plaintext memory model
module tb_pt_check;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic       valid;
  logic [7:0] bad_idx;
  logic [7:0] pt_addr;
  logic [7:0] pt_rddata = 8'd0;

  logic [7:0] mem [256];

  typedef struct {
    int valid;
    int bad;
    int lat;
    int end_addr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  pt_check dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .valid     (valid),
    .bad_idx   (bad_idx),
    .pt_addr   (pt_addr),
    .pt_rddata (pt_rddata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pt_rddata <= mem[pt_addr];
    cyc       <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: first out-of-range byte in mem[1..L], timing from scan rules
  function automatic exp_t model();
    exp_t e;
    int   len;
    int   k;
    len = mem[0];
    k   = 0;
    for (int i = 1; i <= len; i++) begin
      if (mem[i] < 8'h20 || mem[i] > 8'h7E) begin
        k = i;
        break;
      end
    end
    e.valid = (k == 0);
    e.bad   = k;
`ifdef PT_CHECK_EARLY_EXIT_EN
    e.lat      = (k != 0) ? 2 + 2 * k : 2 + 2 * len;
    e.end_addr = (k != 0) ? k : len;
`else
    e.lat      = 2 + 2 * len;
    e.end_addr = len;
`endif
    return e;
  endfunction

  // Monitor: detects accept/complete on rdy and scores against the queue
  initial begin
    bit   prev_rdy = 1'b1;
    bit   busy     = 1'b0;
    int   acc      = 0;
    int   seq[$];
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 1'b0;
      end else if (prev_rdy && !rdy) begin
        busy = 1'b1;
        acc  = cyc;
        seq  = {};
        seq.push_back(pt_addr);
      end else if (busy && !rdy) begin
        if (pt_addr != seq[$]) seq.push_back(pt_addr);
      end else if (busy && !prev_rdy && rdy) begin
        busy = 1'b0;
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("latency", cyc - acc, e.lat);
          chk("valid", valid, e.valid);
          chk("bad_idx", bad_idx, e.bad);
          chk("end_addr", pt_addr, e.end_addr);
          ok = (seq.size() == e.end_addr + 1);
          for (int i = 0; i < seq.size() && ok; i++) ok = (seq[i] == i);
          chk("addr_seq", ok, 1);
        end
      end
      prev_rdy = rdy;
    end
  end

  task automatic wait_rdy();
    int t = 0;
    while (!rdy && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!rdy) chk("rdy_timeout", 0, 1);
  endtask

  task automatic run_scan(input bit noise);
    wait_rdy();
    sb.push_back(model());
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int t = 0; t < 1000 && !rdy; t++) begin
      en = noise ? 1'($urandom % 2) : 1'b0;
      @(negedge clk);
    end
    en = 1'b0;
    if (!rdy) chk("scan_timeout", 0, 1);
  endtask

  task automatic load(input int len, input int fill);
    mem[0] = 8'(len);
    for (int i = 1; i < 256; i++) mem[i] = 8'(fill);
  endtask

  task automatic load_random();
    int len;
    int r;
    len    = $urandom_range(0, 40);
    mem[0] = 8'(len);
    for (int i = 1; i <= len; i++) begin
      r = $urandom % 24;
      if (r == 0)      mem[i] = 8'($urandom);
      else if (r == 1) mem[i] = 8'h1F;
      else if (r == 2) mem[i] = 8'h7F;
      else if (r == 3) mem[i] = 8'h20;
      else if (r == 4) mem[i] = 8'h7E;
      else             mem[i] = 8'($urandom_range(8'h20, 8'h7E));
    end
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    en    = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_rdy", rdy, 1);
    chk("rst_valid", valid, 0);
    chk("rst_bad_idx", bad_idx, 0);
    chk("rst_pt_addr", pt_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    mem[0] = 8'd3; mem[1] = "A"; mem[2] = "b"; mem[3] = "~";
    run_scan(1'b0);

    mem[0] = 8'd4; mem[1] = 8'h41; mem[2] = 8'h7F; mem[3] = 8'h20; mem[4] = 8'h1F;
    run_scan(1'b0);

    load(0, 8'h00);
    run_scan(1'b1);

    load(255, 8'h20);
    run_scan(1'b0);
    mem[255] = 8'h7F;
    run_scan(1'b1);

    // Abort mid-BYTE_WAIT: partial result discarded, no expectation queued
    mem[0] = 8'd3; mem[1] = "x"; mem[2] = "y"; mem[3] = "z";
    wait_rdy();
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_rdy", rdy, 1);
    chk("abort_valid", valid, 0);
    chk("abort_bad_idx", bad_idx, 0);
    chk("abort_pt_addr", pt_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back with en held high: good image then a failing one
    load(2, 8'h68);
    wait_rdy();
    sb.push_back(model());
    en = 1'b1;
    @(negedge clk);
    t = 0;
    while (!rdy && t < 1000) begin
      @(negedge clk);
      t++;
    end
    mem[0] = 8'd3; mem[1] = 8'h7F; mem[2] = 8'h41; mem[3] = 8'h05;
    sb.push_back(model());
    @(negedge clk);
    chk("b2b_accepted", rdy, 0);
    chk("b2b_valid_clr", valid, 0);
    chk("b2b_bad_clr", bad_idx, 0);
    en = 1'b0;
    wait_rdy();
    @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      load_random();
      run_scan(1'($urandom % 2));
    end

    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pt_check.md
Name: pt_check

Overview:
- Plaintext validator that sits directly upstream of the key-search controller.
- After each candidate decryption, it scans the length-prefixed plaintext memory and reports whether every message byte is printable ASCII.
- The crack controller uses `valid` as its key-accept decision.
- It uses the codebase's en/rdy start handshake and a synchronous-read memory port.

Parameters:
- LO, 8'h20: lowest acceptable byte value, inclusive.
- HI, 8'h7E: highest acceptable byte value, inclusive.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  start request; sampled only while rdy=1.
- rdy  output  1  high when idle and able to accept en.
- valid  output  1  result of last completed scan; 1 = all bytes in [LO,HI].
- bad_idx  output  8  index of first failing byte of last scan; 0 if none.
- pt_addr  output  8  plaintext memory read address, registered.
- pt_rddata  input  8  plaintext memory read data; mem[pt_addr] appears one cycle after the address is presented.

Behaviour:
- Reset (asynchronous, rst_n=0): rdy=1, valid=0, bad_idx=0, pt_addr=0, state=IDLE, internal idx/len/ok cleared.
- Reset mid-scan aborts immediately and the partial result is discarded.
- Byte 0 of plaintext memory is the length L (0..255). Message bytes are at addresses 1..L.
- States:
  - IDLE: rdy=1. On en=1 at posedge: rdy<=0, valid<=0, bad_idx<=0, pt_addr<=0, next LEN_WAIT. en=0: stay.
  - LEN_WAIT: memory read latency cycle; next LEN_LATCH.
  - LEN_LATCH: len<=pt_rddata.
    - If pt_rddata==0: valid<=1, rdy<=1, next IDLE (an empty message is valid).
    - Else: idx<=1, ok<=1, pt_addr<=1, next BYTE_WAIT.
  - BYTE_WAIT: latency cycle; next BYTE_CHECK.
  - BYTE_CHECK: byte is good iff LO <= pt_rddata <= HI, unsigned 8-bit compare.
    - On the first bad byte: ok<=0, bad_idx<=idx.
    - If idx==len: valid<=ok&&good, rdy<=1, next IDLE.
    - Else: idx<=idx+1, pt_addr<=idx+1, next BYTE_WAIT.
- Latency: the rdy rising edge occurs 2+2L posedges after the en-accepting edge (L=0 gives 2). This is the full-scan case.
- en while rdy=0 is ignored; no queuing.
- en held high continuously restarts a scan at every IDLE visit.
- valid and bad_idx hold their values in IDLE until the next accepted en, when both clear.
- idx never wraps. L=255 ends at idx=255 with no overflow to 0. idx and len are 8 bits.
- Boundary values 8'h20 and 8'h7E are good. 8'h1F and 8'h7F are bad.
- No memory writes; the read port is read-only.

Optional Feature:
- Macro: PT_CHECK_EARLY_EXIT_EN
- Defined: in BYTE_CHECK, the first bad byte causes an immediate exit (valid<=0, bad_idx<=idx, rdy<=1, next IDLE). Latency becomes 2+2k for a first failure at index k.
- Undefined: always scans all L bytes (constant-time). bad_idx still records the first failure.

Decomposition:
- Shared package arc4_pkg holds:
  - the state enum typedef (IDLE, LEN_WAIT, LEN_LATCH, BYTE_WAIT, BYTE_CHECK);
  - localparams PT_LO=8'h20 and PT_HI=8'h7E, used as parameter defaults;
  - the byte_t typedef (logic [7:0]).
- One sub-module is natural: pt_range_cmp, a combinational in-range compare used by BYTE_CHECK. The rest is a single FSM.

Test Plan:
- Reset, then idle: rdy=1, valid=0, bad_idx=0, pt_addr=0. Asserting rst_n=0 mid-BYTE_WAIT returns these values immediately.
- Mem = {3,"A","b","~"}, pulse en: pt_addr sequence 0,1,2,3. rdy rises exactly 8 edges after acceptance. valid=1, bad_idx=0.
- Mem = {4,8'h41,8'h7F,8'h20,8'h1F}, full scan (macro undefined): rdy after 10 edges, valid=0, bad_idx=2.
  - Same memory with the macro defined: rdy after 6 edges, valid=0, bad_idx=2.
- Mem = {0}: rdy after 2 edges, valid=1, pt_addr never leaves 0. en pulses while rdy=0 are ignored and change nothing.
- Mem len=255, all bytes 8'h20: rdy after 512 edges, valid=1, pt_addr ends at 255 with no wrap. Changing byte 255 to 8'h7F gives valid=0, bad_idx=255.
- Back-to-back runs with en held high: valid clears on each new acceptance, and the second result is independent of the first.
